// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - door-lock servo command sequencer with settle hold-off, auto-relock and lock abort
module lock_sequencer #(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned SETTLE_MS = 500,
  parameter int unsigned RELOCK_MS = 10_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_lock,
  input  logic       door_closed,
  output logic       cmd_ready,
  output logic       lock,
  output logic       done,
  output logic       err,
  output logic       auto_relock,
  output logic [1:0] state
);

  localparam logic [31:0] SETTLE_TICKS = 32'((CLK_HZ / 1000) * SETTLE_MS);
  localparam logic [31:0] RELOCK_TICKS = 32'((CLK_HZ / 1000) * RELOCK_MS);
  localparam logic [31:0] SETTLE_LAST  = SETTLE_TICKS - 32'd1;
  localparam logic [31:0] RELOCK_LAST  = RELOCK_TICKS - 32'd1;

  typedef enum logic [1:0] {
    S_LOCKED    = 2'd0,
    S_UNLOCKING = 2'd1,
    S_UNLOCKED  = 2'd2,
    S_LOCKING   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        lock_q, lock_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        relock_q, relock_d;
  logic [31:0] cnt_q, cnt_d;
  logic        dc_meta_q;
  logic        dc_s_q;
  logic        accept;

  // Commands are only taken while the servo is parked in an end position.
  assign cmd_ready   = (state_q == S_LOCKED) || (state_q == S_UNLOCKED);
  assign accept      = cmd_valid && cmd_ready;
  assign lock        = lock_q;
  assign done        = done_q;
  assign err         = err_q;
  assign auto_relock = relock_q;
  assign state       = state_q;

  // Next-state, counter and pulse decode; every state change clears the counter.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    relock_d = 1'b0;
    case (state_q)
      S_LOCKED: begin
        if (accept) begin
          if (cmd_lock) begin
            done_d = 1'b1;
          end else begin
            state_d = S_UNLOCKING;
            lock_d  = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      S_UNLOCKING: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_UNLOCKED;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_UNLOCKED: begin
        // An accepted command always beats a relock expiry in the same cycle.
        if (accept) begin
          if (!cmd_lock) begin
            done_d = 1'b1;
            cnt_d  = '0;
          end else if (dc_s_q) begin
            state_d = S_LOCKING;
            lock_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end else if (dc_s_q) begin
          if (cnt_q == RELOCK_LAST) begin
            state_d  = S_LOCKING;
            lock_d   = 1'b1;
            relock_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      S_LOCKING: begin
        // Door opening mid-travel backs the bolt out, even on the final settle cycle.
        if (!dc_s_q) begin
          state_d = S_UNLOCKING;
          lock_d  = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_LOCKED;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_LOCKED;
        lock_d  = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  // State, registered outputs, counter and door sensor synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOCKED;
      lock_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      relock_q  <= 1'b0;
      cnt_q     <= '0;
      dc_meta_q <= 1'b0;
      dc_s_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      done_q    <= done_d;
      err_q     <= err_d;
      relock_q  <= relock_d;
      cnt_q     <= cnt_d;
      dc_meta_q <= door_closed;
      dc_s_q    <= dc_meta_q;
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - directed self-checking bench for lock_sequencer
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_lock;
  logic       door_closed;
  logic       cmd_ready;
  logic       lock;
  logic       done;
  logic       err;
  logic       auto_relock;
  logic [1:0] state;
  logic [6:0] obs;

  int errors = 0;
  int checks = 0;

  // {state, lock, cmd_ready, done, err, auto_relock}
  localparam logic [6:0] E_IDLE_L  = 7'b00_1_1_000;
  localparam logic [6:0] E_DONE_L  = 7'b00_1_1_100;
  localparam logic [6:0] E_UNLKG   = 7'b01_0_0_000;
  localparam logic [6:0] E_ABORT   = 7'b01_0_0_010;
  localparam logic [6:0] E_DONE_U  = 7'b10_0_1_100;
  localparam logic [6:0] E_IDLE_U  = 7'b10_0_1_000;
  localparam logic [6:0] E_ERR_U   = 7'b10_0_1_010;
  localparam logic [6:0] E_LOCKG   = 7'b11_1_0_000;
  localparam logic [6:0] E_RELOCK  = 7'b11_1_0_001;

  lock_sequencer #(
    .CLK_HZ(1000),
    .SETTLE_MS(3),
    .RELOCK_MS(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_lock(cmd_lock),
    .door_closed(door_closed),
    .cmd_ready(cmd_ready),
    .lock(lock),
    .done(done),
    .err(err),
    .auto_relock(auto_relock),
    .state(state)
  );

  assign obs = {state, lock, cmd_ready, done, err, auto_relock};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; door_closed = 1'b1; cmd_valid = 1'b0; cmd_lock = 1'b0;
    repeat (3) step();
    checks++;
    if (obs !== E_IDLE_L) begin
      errors++; $display("FAIL reset_hold: got %b expected %b", obs, E_IDLE_L);
    end
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (obs !== E_IDLE_L) begin
      errors++; $display("FAIL reset_release: got %b expected %b", obs, E_IDLE_L);
    end
  endtask

  task automatic test_locked_lock();
    cmd_valid = 1'b1; cmd_lock = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (obs !== E_DONE_L) begin
      errors++; $display("FAIL locked_lock_done: got %b expected %b", obs, E_DONE_L);
    end
    step();
    checks++;
    if (obs !== E_IDLE_L) begin
      errors++; $display("FAIL locked_lock_after: got %b expected %b", obs, E_IDLE_L);
    end
  endtask

  task automatic test_unlock();
    cmd_valid = 1'b1; cmd_lock = 1'b0;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== E_UNLKG) begin
        errors++; $display("FAIL unlocking_cycle%0d: got %b expected %b", i, obs, E_UNLKG);
      end
      if (i < 2) step();
    end
    step();
    checks++;
    if (obs !== E_DONE_U) begin
      errors++; $display("FAIL unlock_done: got %b expected %b", obs, E_DONE_U);
    end
  endtask

  task automatic test_auto_relock();
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (obs !== E_IDLE_U) begin
        errors++; $display("FAIL relock_wait%0d: got %b expected %b", k, obs, E_IDLE_U);
      end
    end
    step();
    checks++;
    if (obs !== E_RELOCK) begin
      errors++; $display("FAIL relock_fire: got %b expected %b", obs, E_RELOCK);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (obs !== E_LOCKG) begin
        errors++; $display("FAIL relock_locking%0d: got %b expected %b", k, obs, E_LOCKG);
      end
    end
    step();
    checks++;
    if (obs !== E_DONE_L) begin
      errors++; $display("FAIL relock_done: got %b expected %b", obs, E_DONE_L);
    end
  endtask

  task automatic test_relock_restart();
    cmd_valid = 1'b1; cmd_lock = 1'b0;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    checks++;
    if (obs !== E_DONE_U) begin
      errors++; $display("FAIL restart_entry: got %b expected %b", obs, E_DONE_U);
    end
    for (int k = 1; k <= 22; k++) begin
      if (k == 8) door_closed = 1'b0;
      if (k == 12) door_closed = 1'b1;
      step();
      checks++;
      if (obs !== E_IDLE_U) begin
        errors++; $display("FAIL restart_wait%0d: got %b expected %b", k, obs, E_IDLE_U);
      end
    end
    step();
    checks++;
    if (obs !== E_RELOCK) begin
      errors++; $display("FAIL restart_fire: got %b expected %b", obs, E_RELOCK);
    end
    repeat (3) step();
    checks++;
    if (obs !== E_DONE_L) begin
      errors++; $display("FAIL restart_locked: got %b expected %b", obs, E_DONE_L);
    end
  endtask

  task automatic test_lock_door_open();
    cmd_valid = 1'b1; cmd_lock = 1'b0;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    door_closed = 1'b0;
    repeat (3) step();
    checks++;
    if (obs !== E_IDLE_U) begin
      errors++; $display("FAIL open_idle: got %b expected %b", obs, E_IDLE_U);
    end
    cmd_valid = 1'b1; cmd_lock = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (obs !== E_ERR_U) begin
      errors++; $display("FAIL open_lock_err: got %b expected %b", obs, E_ERR_U);
    end
    step();
    checks++;
    if (obs !== E_IDLE_U) begin
      errors++; $display("FAIL open_lock_after: got %b expected %b", obs, E_IDLE_U);
    end
  endtask

  task automatic test_abort();
    door_closed = 1'b1;
    repeat (3) step();
    cmd_valid = 1'b1; cmd_lock = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (obs !== E_LOCKG) begin
      errors++; $display("FAIL abort_start: got %b expected %b", obs, E_LOCKG);
    end
    door_closed = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (obs !== E_LOCKG) begin
        errors++; $display("FAIL abort_locking%0d: got %b expected %b", k, obs, E_LOCKG);
      end
    end
    step();
    checks++;
    if (obs !== E_ABORT) begin
      errors++; $display("FAIL abort_pulse: got %b expected %b", obs, E_ABORT);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (obs !== E_UNLKG) begin
        errors++; $display("FAIL abort_unlocking%0d: got %b expected %b", k, obs, E_UNLKG);
      end
    end
    step();
    checks++;
    if (obs !== E_DONE_U) begin
      errors++; $display("FAIL abort_unlocked: got %b expected %b", obs, E_DONE_U);
    end
  endtask

  task automatic test_back_to_back();
    door_closed = 1'b1;
    for (int k = 7; k <= 17; k++) begin
      step();
      checks++;
      if (obs !== E_IDLE_U) begin
        errors++; $display("FAIL tie_wait%0d: got %b expected %b", k, obs, E_IDLE_U);
      end
    end
    cmd_valid = 1'b1; cmd_lock = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs !== E_LOCKG) begin
        errors++; $display("FAIL tie_locking%0d: got %b expected %b", k, obs, E_LOCKG);
      end
      step();
    end
    checks++;
    if (obs !== E_DONE_L) begin
      errors++; $display("FAIL tie_locked: got %b expected %b", obs, E_DONE_L);
    end
    cmd_valid = 1'b1; cmd_lock = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    checks++;
    if (obs !== E_UNLKG) begin
      errors++; $display("FAIL midmove_unlocking: got %b expected %b", obs, E_UNLKG);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_IDLE_L) begin
      errors++; $display("FAIL midmove_async_reset: got %b expected %b", obs, E_IDLE_L);
    end
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (obs !== E_IDLE_L) begin
        errors++; $display("FAIL midmove_after%0d: got %b expected %b", k, obs, E_IDLE_L);
      end
    end
  endtask

  initial begin
    test_reset();
    test_locked_lock();
    test_unlock();
    test_auto_relock();
    test_relock_restart();
    test_lock_door_open();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, reached %0t", $time);
    $fatal(1);
  end

endmodule
